// File: rtl/spi_seq_sched_pkg.sv
// Shared opcodes, FSM encoding, status-byte layout and marker bytes for spi_seq_sched.
package spi_seq_sched_pkg;

   typedef enum logic [1:0] {
      OP_READ   = 2'b00,
      OP_CLEAR  = 2'b01,
      OP_SKIP   = 2'b10,
      OP_STATUS = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_STREAM,
      ST_SKIP,
      ST_DONE,
      ST_ERROR,
      ST_STAT
   } state_t;

   localparam int STAT_ERR_BIT  = 7;
   localparam int STAT_BUSY_BIT = 6;
   localparam int STAT_SEL_LSB  = 4;
   localparam int STAT_CNT_LSB  = 0;

   localparam logic [7:0] SYNC_MARK = 8'hA5;
   localparam logic [7:0] ERR_MARK  = 8'hFF;

   function automatic logic [7:0] status_byte(input logic e, input logic b,
                                              input logic [1:0] s, input logic [3:0] c);
      logic [7:0] r;
      r                       = '0;
      r[STAT_ERR_BIT]         = e;
      r[STAT_BUSY_BIT]        = b;
      r[STAT_SEL_LSB +: 2]    = s;
      r[STAT_CNT_LSB +: 4]    = c;
      return r;
   endfunction

endpackage

// File: rtl/spi_seq_sched_if.sv
// Byte-level link between the SPI slave front end (master modport) and the scheduler (slave modport).
interface spi_seq_sched_if #(parameter int DW = 8);
   // All inputs are single-cycle strobes with no back-pressure: msg_start/msg_end frame a message,
   // rx_valid qualifies rx_data, tx_req means tx_data is being latched for the next MISO slot.
   logic          msg_start;
   logic          msg_end;
   logic          rx_valid;
   logic [DW-1:0] rx_data;
   logic          tx_req;
   logic [DW-1:0] tx_data;

   modport master (output msg_start, msg_end, rx_valid, rx_data, tx_req, input tx_data);
   modport slave  (input msg_start, msg_end, rx_valid, rx_data, tx_req, output tx_data);
endinterface

// File: rtl/spi_seq_sched_stepper.sv
// Down-counter issuing back-to-back one-cycle step pulses; the first pulse appears the cycle after load.
module spi_seq_stepper (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [5:0] count,
   input  logic       abort,
   output logic       step,
   output logic       busy
);
   logic [5:0] remain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remain <= '0;
         step   <= 1'b0;
      end else if (abort) begin
         remain <= '0;
         step   <= 1'b0;
      end else if (load) begin
         step   <= (count != 6'd0);
         remain <= (count != 6'd0) ? count - 6'd1 : 6'd0;
      end else if (remain != 6'd0) begin
         step   <= 1'b1;
         remain <= remain - 6'd1;
      end else begin
         step   <= 1'b0;
      end
   end

   assign busy = step | (remain != 6'd0);
endmodule

// File: rtl/spi_seq_sched.sv
// Command scheduler between an SPI byte front end and NGEN sequence generators.
// Optional XOR checksum of streamed bytes: define SPI_SEQ_SCHED_CKSUM_EN.
module spi_seq_sched
   import spi_seq_sched_pkg::*;
#(
   parameter int NGEN = 4,
   parameter int DW   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spi_seq_sched_if.slave       fe,
   input  logic [NGEN*DW-1:0]   gen_data,
   output logic [NGEN-1:0]      gen_step,
   output logic [NGEN-1:0]      gen_clear,
   output logic                 busy,
   output logic                 err,
   output state_t               state
);
   state_t          state_n;
   logic [DW-1:0]   tx_q, tx_n;
   logic            err_n;
   logic [1:0]      cur_sel, sel_n;
   logic [3:0]      stream_cnt, cnt_n;
   logic [NGEN-1:0] clr_n;
   logic [1:0]      rd_pipe, pipe_n;
   logic            stat_first, stat_first_n;
   logic [DW-1:0]   ck_byte;
   logic            step_load, step_pulse, step_busy;
   logic [5:0]      step_n;
   opcode_t         opcode;
   logic [5:0]      arg;
   logic            sel_ok;

   function automatic logic [DW-1:0] pick(input logic [NGEN*DW-1:0] d, input logic [1:0] s);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < NGEN; i++)
         if (s == 2'(i)) r = d[i*DW +: DW];
      return r;
   endfunction

`ifdef SPI_SEQ_SCHED_CKSUM_EN
   logic [DW-1:0] cksum, ck_n;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cksum <= '0;
      else        cksum <= ck_n;
   end
   assign ck_byte = cksum;
`else
   assign ck_byte = '0;
`endif

   assign opcode = opcode_t'(fe.rx_data[7:6]);
   assign arg    = fe.rx_data[5:0];
   assign sel_ok = int'(arg[1:0]) < NGEN;

   always_comb begin
      state_n      = state;
      tx_n         = tx_q;
      err_n        = err;
      sel_n        = cur_sel;
      cnt_n        = stream_cnt;
      clr_n        = '0;
      pipe_n       = {rd_pipe[0], 1'b0};
      stat_first_n = stat_first;
      step_load    = 1'b0;
      step_n       = '0;
`ifdef SPI_SEQ_SCHED_CKSUM_EN
      ck_n         = cksum;
`endif
      // Third cycle after a stream tx_req: the generator has taken its step, refresh MISO.
      if (rd_pipe[1]) tx_n = pick(gen_data, cur_sel);

      if (fe.msg_start) begin
         state_n = ST_CMD;
         tx_n    = SYNC_MARK;
         pipe_n  = '0;
      end else if (fe.msg_end) begin
         state_n = ST_IDLE;
         tx_n    = SYNC_MARK;
         pipe_n  = '0;
      end else begin
         case (state)
            ST_CMD: if (fe.rx_valid) begin
               case (opcode)
                  OP_READ: if (sel_ok) begin
                     sel_n   = arg[1:0];
                     cnt_n   = '0;
                     tx_n    = pick(gen_data, arg[1:0]);
                     state_n = ST_STREAM;
`ifdef SPI_SEQ_SCHED_CKSUM_EN
                     ck_n    = '0;
`endif
                  end else begin
                     err_n   = 1'b1;
                     tx_n    = ERR_MARK;
                     state_n = ST_ERROR;
                  end
                  OP_CLEAR: if (sel_ok) begin
                     for (int i = 0; i < NGEN; i++)
                        if (arg[1:0] == 2'(i)) clr_n[i] = 1'b1;
                     sel_n   = arg[1:0];
                     tx_n    = '0;
                     state_n = ST_DONE;
                  end else begin
                     err_n   = 1'b1;
                     tx_n    = ERR_MARK;
                     state_n = ST_ERROR;
                  end
                  OP_SKIP: begin
                     step_load = 1'b1;
                     step_n    = arg;
                     state_n   = ST_SKIP;
                  end
                  OP_STATUS: begin
                     tx_n         = status_byte(err, step_busy, cur_sel, stream_cnt);
                     err_n        = 1'b0;
                     stat_first_n = 1'b1;
                     state_n      = ST_STAT;
                  end
               endcase
            end
            ST_STREAM: if (fe.tx_req) begin
               step_load = 1'b1;
               step_n    = 6'd1;
               cnt_n     = stream_cnt + 4'd1;
               pipe_n[0] = 1'b1;
`ifdef SPI_SEQ_SCHED_CKSUM_EN
               ck_n      = cksum ^ tx_q;
`endif
            end
            ST_SKIP: if (!step_busy) state_n = ST_DONE;
            ST_STAT: if (fe.tx_req) begin
               tx_n         = stat_first ? ck_byte : '0;
               stat_first_n = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         tx_q       <= SYNC_MARK;
         err        <= 1'b0;
         cur_sel    <= '0;
         stream_cnt <= '0;
         gen_clear  <= '0;
         rd_pipe    <= '0;
         stat_first <= 1'b0;
      end else begin
         state      <= state_n;
         tx_q       <= tx_n;
         err        <= err_n;
         cur_sel    <= sel_n;
         stream_cnt <= cnt_n;
         gen_clear  <= clr_n;
         rd_pipe    <= pipe_n;
         stat_first <= stat_first_n;
      end
   end

   spi_seq_stepper u_stepper (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (step_load),
      .count (step_n),
      .abort (fe.msg_start | fe.msg_end),
      .step  (step_pulse),
      .busy  (step_busy)
   );

   always_comb begin
      gen_step = '0;
      for (int i = 0; i < NGEN; i++)
         if (cur_sel == 2'(i)) gen_step[i] = step_pulse;
   end

   assign busy       = step_busy;
   assign fe.tx_data = tx_q;
endmodule

// File: tb/tb_spi_seq_sched.sv
// Randomized self-checking bench for spi_seq_sched against a closed-form generator/command model.
`timescale 1ns/1ps
module tb_spi_seq_sched;
   import spi_seq_sched_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_seq_sched_if #(.DW(8)) fe ();
   spi_seq_sched_if #(.DW(8)) fe2 ();

   logic [31:0] gen_data;
   logic [3:0]  gen_step, gen_clear;
   logic        busy, err;
   state_t      state;
   logic [1:0]  gen_step2, gen_clear2;
   logic        busy2, err2;
   state_t      state2;

   spi_seq_sched #(.NGEN(4), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .fe(fe), .gen_data(gen_data), .gen_step(gen_step),
      .gen_clear(gen_clear), .busy(busy), .err(err), .state(state));

   spi_seq_sched #(.NGEN(2), .DW(8)) dut2 (
      .clk(clk), .rst_n(rst_n), .fe(fe2), .gen_data(gen_data[15:0]), .gen_step(gen_step2),
      .gen_clear(gen_clear2), .busy(busy2), .err(err2), .state(state2));

   // Generator environment: gen1 is fibonacci, the others count by 2*i+1.
   logic [7:0] gval [4];
   logic [7:0] fib_b;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) gval[i] <= 8'h00;
         fib_b <= 8'h01;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (gen_clear[i]) begin
               gval[i] <= 8'h00;
               if (i == 1) fib_b <= 8'h01;
            end else if (gen_step[i]) begin
               if (i == 1) begin
                  gval[1] <= fib_b;
                  fib_b   <= gval[1] + fib_b;
               end else begin
                  gval[i] <= gval[i] + 8'(2*i+1);
               end
            end
         end
      end
   end
   assign gen_data = {gval[3], gval[2], gval[1], gval[0]};

   int step_cnt [4];
   int clr_cnt [4];
   int onehot_viol;
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (gen_step[i])  step_cnt[i]++;
         if (gen_clear[i]) clr_cnt[i]++;
      end
      if ($countones({gen_step, gen_clear}) > 1) onehot_viol++;
   end

   int         n_cmp, n_bad;
   int         m_idx [4];
   logic [1:0] m_sel;
   logic [3:0] m_cnt;
   logic [7:0] m_ck;
   logic [7:0] exp_q [$];

   function automatic logic [7:0] ref_val(input int g, input int k);
      logic [7:0] a, b, t;
      if (g != 1) return 8'(k * (2*g+1));
      a = 8'h00;
      b = 8'h01;
      for (int j = 0; j < k; j++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic start_cmd(input logic [7:0] b);
      fe.msg_start = 1'b1; cyc(1); fe.msg_start = 1'b0; cyc(1);
      fe.rx_valid = 1'b1; fe.rx_data = b; cyc(1);
      fe.rx_valid = 1'b0; fe.rx_data = 8'($urandom); cyc(1);
   endtask

   task automatic end_msg();
      fe.msg_end = 1'b1; cyc(1); fe.msg_end = 1'b0;
      n_cmp++; if (fe.tx_data !== SYNC_MARK) begin n_bad++; $display("FAIL end_tx got %h exp %h", fe.tx_data, SYNC_MARK); end
      n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL end_state got %0d exp %0d", state, ST_IDLE); end
      cyc(1);
   endtask

   task automatic pull(output logic [7:0] v, input logic stray_rx);
      v = fe.tx_data;
      fe.tx_req = 1'b1;
      if (stray_rx) begin fe.rx_valid = 1'b1; fe.rx_data = 8'($urandom); end
      cyc(1);
      fe.tx_req = 1'b0; fe.rx_valid = 1'b0;
      cyc(5);
   endtask

   task automatic msg_clear(input logic [7:0] cmd);
      int base;
      base = clr_cnt[cmd[1:0]];
      start_cmd(cmd);
      m_idx[cmd[1:0]] = 0;
      m_sel = cmd[1:0];
      n_cmp++; if (clr_cnt[cmd[1:0]] - base !== 1) begin n_bad++; $display("FAIL clear_pulses got %0d exp 1", clr_cnt[cmd[1:0]] - base); end
      n_cmp++; if (fe.tx_data !== 8'h00) begin n_bad++; $display("FAIL clear_tx got %h exp 00", fe.tx_data); end
      n_cmp++; if (state !== ST_DONE) begin n_bad++; $display("FAIL clear_state got %0d exp %0d", state, ST_DONE); end
      end_msg();
   endtask

   task automatic msg_skip(input int n);
      int base;
      base = step_cnt[m_sel];
      start_cmd(8'h80 | 8'(n));
      cyc(n + 2);
      m_idx[m_sel] += n;
      n_cmp++; if (step_cnt[m_sel] - base !== n) begin n_bad++; $display("FAIL skip_pulses got %0d exp %0d", step_cnt[m_sel] - base, n); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL skip_busy got %b exp 0", busy); end
      n_cmp++; if (state !== ST_DONE) begin n_bad++; $display("FAIL skip_state got %0d exp %0d", state, ST_DONE); end
      end_msg();
   endtask

   task automatic msg_read(input int sel, input int pulls);
      int base [4];
      logic [7:0] v, e;
      for (int i = 0; i < 4; i++) base[i] = step_cnt[i];
      start_cmd(8'(sel));
      m_sel = 2'(sel); m_cnt = 4'd0; m_ck = 8'h00;
      n_cmp++; if (fe.tx_data !== ref_val(sel, m_idx[sel])) begin n_bad++; $display("FAIL read_first got %h exp %h", fe.tx_data, ref_val(sel, m_idx[sel])); end
      for (int p = 0; p < pulls; p++) begin
         exp_q.push_back(ref_val(sel, m_idx[sel]));
         m_ck = m_ck ^ ref_val(sel, m_idx[sel]);
         m_idx[sel]++;
         m_cnt++;
      end
      for (int p = 0; p < pulls; p++) begin
         pull(v, p == 1);
         e = exp_q.pop_front();
         n_cmp++; if (v !== e) begin n_bad++; $display("FAIL stream_byte%0d got %h exp %h", p, v, e); end
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (step_cnt[i] - base[i] !== ((i == sel) ? pulls : 0)) begin
            n_bad++; $display("FAIL stream_steps_gen%0d got %0d exp %0d", i, step_cnt[i] - base[i], (i == sel) ? pulls : 0);
         end
      end
      n_cmp++; if (state !== ST_STREAM) begin n_bad++; $display("FAIL stream_state got %0d exp %0d", state, ST_STREAM); end
      end_msg();
   endtask

   task automatic msg_status();
      logic [7:0] st, v, ck;
      st = {1'b0, 1'b0, m_sel, m_cnt};
`ifdef SPI_SEQ_SCHED_CKSUM_EN
      ck = m_ck;
`else
      ck = 8'h00;
`endif
      start_cmd(8'hC0 | 8'($urandom_range(0, 63)));
      n_cmp++; if (fe.tx_data !== st) begin n_bad++; $display("FAIL status_tx got %h exp %h", fe.tx_data, st); end
      pull(v, 1'b0);
      n_cmp++; if (v !== st) begin n_bad++; $display("FAIL status_b0 got %h exp %h", v, st); end
      pull(v, 1'b0);
      n_cmp++; if (v !== ck) begin n_bad++; $display("FAIL status_b1 got %h exp %h", v, ck); end
      pull(v, 1'b0);
      n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL status_b2 got %h exp 00", v); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL status_err got %b exp 0", err); end
      end_msg();
   endtask

   task automatic test_reset();
      logic [7:0] v;
      int base;
      cyc(2);
      n_cmp++; if (fe.tx_data !== 8'hA5) begin n_bad++; $display("FAIL rst_tx got %h exp a5", fe.tx_data); end
      n_cmp++; if (gen_step !== 4'h0 || gen_clear !== 4'h0) begin n_bad++; $display("FAIL rst_gen got %h/%h exp 0/0", gen_step, gen_clear); end
      n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_flags got %b%b exp 00", busy, err); end
      n_cmp++; if (state !== ST_IDLE) begin n_bad++; $display("FAIL rst_state got %0d exp %0d", state, ST_IDLE); end
      rst_n = 1'b1;
      cyc(2);
      fe.msg_start = 1'b1; cyc(1); fe.msg_start = 1'b0; cyc(2);
      n_cmp++; if (fe.tx_data !== 8'hA5) begin n_bad++; $display("FAIL nocmd_tx got %h exp a5", fe.tx_data); end
      n_cmp++; if (state !== ST_CMD) begin n_bad++; $display("FAIL nocmd_state got %0d exp %0d", state, ST_CMD); end
      base = step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3];
      pull(v, 1'b0);
      n_cmp++; if (step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3] !== base || gen_clear !== 4'h0) begin
         n_bad++; $display("FAIL nocmd_txreq got %0d steps exp 0", step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3] - base);
      end
      end_msg();
   endtask

   task automatic test_read_fib();
      msg_clear(8'h41);
      msg_skip(4);
      msg_read(1, 3);
      msg_status();
   endtask

   task automatic test_clear_skip();
      int base;
      msg_clear(8'h45);
      base = step_cnt[1];
      fe.msg_start = 1'b1; cyc(1); fe.msg_start = 1'b0; cyc(1);
      fe.rx_valid = 1'b1; fe.rx_data = 8'h83; cyc(1); fe.rx_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (gen_step !== ((k < 3) ? 4'b0010 : 4'b0000) || busy !== (k < 3)) begin
            n_bad++; $display("FAIL skip3_cycle%0d got step %b busy %b", k, gen_step, busy);
         end
         cyc(1);
      end
      m_idx[1] += 3;
      n_cmp++; if (step_cnt[1] - base !== 3) begin n_bad++; $display("FAIL skip3_total got %0d exp 3", step_cnt[1] - base); end
      n_cmp++; if (state !== ST_DONE) begin n_bad++; $display("FAIL skip3_state got %0d exp %0d", state, ST_DONE); end
      end_msg();
   endtask

   task automatic test_skip_abort();
      int base, k;
      base = step_cnt[1];
      fe.msg_start = 1'b1; cyc(1); fe.msg_start = 1'b0; cyc(1);
      fe.rx_valid = 1'b1; fe.rx_data = 8'hBF; cyc(1); fe.rx_valid = 1'b0;
      k = 0;
      while (step_cnt[1] - base < 10 && k < 40) begin cyc(1); k++; end
      n_cmp++; if (k >= 40) begin n_bad++; $display("FAIL abort_wait got %0d steps exp 10", step_cnt[1] - base); end
      fe.msg_end = 1'b1; cyc(1); fe.msg_end = 1'b0;
      n_cmp++; if (gen_step !== 4'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_stop got %b/%b exp 0/0", gen_step, busy); end
      n_cmp++; if (state !== ST_IDLE || fe.tx_data !== 8'hA5) begin n_bad++; $display("FAIL abort_idle got %0d/%h exp %0d/a5", state, fe.tx_data, ST_IDLE); end
      cyc(3);
      n_cmp++; if (step_cnt[1] - base !== 10) begin n_bad++; $display("FAIL abort_total got %0d exp 10", step_cnt[1] - base); end
      m_idx[1] += 10;
      // Restart mid-SKIP with msg_start and msg_end together: start must win.
      base = step_cnt[1];
      fe.msg_start = 1'b1; cyc(1); fe.msg_start = 1'b0; cyc(1);
      fe.rx_valid = 1'b1; fe.rx_data = 8'h9E; cyc(1); fe.rx_valid = 1'b0;
      cyc(4);
      fe.msg_start = 1'b1; fe.msg_end = 1'b1; cyc(1); fe.msg_start = 1'b0; fe.msg_end = 1'b0;
      n_cmp++; if (state !== ST_CMD || gen_step !== 4'h0) begin n_bad++; $display("FAIL restart got %0d/%b exp %0d/0", state, gen_step, ST_CMD); end
      cyc(2);
      n_cmp++; if (step_cnt[1] - base !== 5) begin n_bad++; $display("FAIL restart_total got %0d exp 5", step_cnt[1] - base); end
      m_idx[1] += 5;
      fe.rx_valid = 1'b1; fe.rx_data = 8'h01; cyc(1); fe.rx_valid = 1'b0; cyc(1);
      m_sel = 2'd1; m_cnt = 4'd0; m_ck = 8'h00;
      n_cmp++; if (fe.tx_data !== ref_val(1, m_idx[1])) begin n_bad++; $display("FAIL restart_read got %h exp %h", fe.tx_data, ref_val(1, m_idx[1])); end
      end_msg();
   endtask

   task automatic test_random();
      int op, sel;
      for (int it = 0; it < 12; it++) begin
         op  = $urandom_range(0, 3);
         sel = $urandom_range(0, 3);
         case (op)
            0: msg_clear(8'h40 | 8'(sel) | (8'($urandom_range(0, 15)) << 2));
            1: msg_skip($urandom_range(0, 12));
            2: msg_read(sel, $urandom_range(1, 4));
            default: msg_status();
         endcase
      end
   endtask

   task automatic test_error();
      fe2.msg_start = 1'b1; cyc(1); fe2.msg_start = 1'b0; cyc(1);
      fe2.rx_valid = 1'b1; fe2.rx_data = 8'h03; cyc(1); fe2.rx_valid = 1'b0; cyc(1);
      n_cmp++; if (err2 !== 1'b1 || fe2.tx_data !== 8'hFF) begin n_bad++; $display("FAIL err_set got %b/%h exp 1/ff", err2, fe2.tx_data); end
      fe2.rx_valid = 1'b1; fe2.rx_data = 8'h00; cyc(1); fe2.rx_valid = 1'b0; cyc(3);
      n_cmp++; if (fe2.tx_data !== 8'hFF || state2 !== ST_ERROR) begin n_bad++; $display("FAIL err_hold got %h/%0d exp ff/%0d", fe2.tx_data, state2, ST_ERROR); end
      fe2.msg_end = 1'b1; cyc(1); fe2.msg_end = 1'b0; cyc(1);
      n_cmp++; if (fe2.tx_data !== 8'hA5 || err2 !== 1'b1) begin n_bad++; $display("FAIL err_end got %h/%b exp a5/1", fe2.tx_data, err2); end
      for (int s = 0; s < 2; s++) begin
         fe2.msg_start = 1'b1; cyc(1); fe2.msg_start = 1'b0; cyc(1);
         fe2.rx_valid = 1'b1; fe2.rx_data = 8'hC0; cyc(1); fe2.rx_valid = 1'b0; cyc(1);
         n_cmp++; if (fe2.tx_data !== ((s == 0) ? 8'h80 : 8'h00) || err2 !== 1'b0) begin
            n_bad++; $display("FAIL err_status%0d got %h/%b exp %h/0", s, fe2.tx_data, err2, (s == 0) ? 8'h80 : 8'h00);
         end
         fe2.msg_end = 1'b1; cyc(1); fe2.msg_end = 1'b0; cyc(1);
      end
      fe2.msg_start = 1'b1; cyc(1); fe2.msg_start = 1'b0; cyc(1);
      fe2.rx_valid = 1'b1; fe2.rx_data = 8'h43; cyc(1); fe2.rx_valid = 1'b0;
      n_cmp++; if (gen_clear2 !== 2'b00) begin n_bad++; $display("FAIL err_clear_pulse got %b exp 00", gen_clear2); end
      cyc(1);
      n_cmp++; if (err2 !== 1'b1 || fe2.tx_data !== 8'hFF) begin n_bad++; $display("FAIL err_clear got %b/%h exp 1/ff", err2, fe2.tx_data); end
      fe2.msg_end = 1'b1; cyc(1); fe2.msg_end = 1'b0; cyc(1);
   endtask

   task automatic test_onehot();
      n_cmp++; if (onehot_viol !== 0) begin n_bad++; $display("FAIL onehot got %0d violations exp 0", onehot_viol); end
   endtask

   initial begin
      fe.msg_start = 0; fe.msg_end = 0; fe.rx_valid = 0; fe.rx_data = 0; fe.tx_req = 0;
      fe2.msg_start = 0; fe2.msg_end = 0; fe2.rx_valid = 0; fe2.rx_data = 0; fe2.tx_req = 0;
      n_cmp = 0; n_bad = 0; m_sel = 0; m_cnt = 0; m_ck = 0;
      for (int i = 0; i < 4; i++) m_idx[i] = 0;
      test_reset();
      test_read_fib();
      test_clear_skip();
      test_skip_abort();
      test_random();
      test_error();
      test_onehot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end
endmodule
